// File: rtl/mtime_multi.sv
// Memory-mapped machine timer: programmable tick divider, NUM_CMP 64-bit compare channels
// with per-channel interrupt enable, and a hi-word shadow for coherent 64-bit reads.
module mtime_multi #(
   parameter int CLK_PERIOD = 10,
   parameter int NUM_CMP    = 4,
   parameter int ADDR_W     = $clog2(4 + 2 * NUM_CMP)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wr_data,
   input  logic [3:0]        wr_strobe,
   output logic [31:0]       rd_data,
   output logic [63:0]       time_rd_data,
   output logic [NUM_CMP-1:0] irq,
   output logic              irq_any
);

   localparam logic [15:0]       DIV_RST    = 16'(1000 / CLK_PERIOD - 1);
   localparam logic [31:0]       CTRL_MASK  = 32'hFFFF_0001 | (32'((1 << NUM_CMP) - 1) << 8);
   localparam logic [31:0]       CTRL_RST   = {DIV_RST, 16'h0001};
   localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_PEND     = ADDR_W'(3);

   function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? data[8*b +: 8] : cur[8*b +: 8];
      end
      return res;
   endfunction

   logic [63:0]        mtime_r;
   logic [63:0]        cmp_r [NUM_CMP];
   logic [31:0]        ctrl_r;
   logic [15:0]        cnt_r;
   logic [31:0]        shadow_r;

   logic               en_s;
   logic [NUM_CMP-1:0] ie_s;
   logic [15:0]        div_s;
   logic               ctrl_wr_s;
   logic               tick_s;
   logic [63:0]        mtime_next_s;
   logic [NUM_CMP-1:0] pend_s;

   // Control decode, tick generation and compare status
   always_comb begin
      en_s         = ctrl_r[0];
      ie_s         = ctrl_r[8 +: NUM_CMP];
      div_s        = ctrl_r[31:16];
      ctrl_wr_s    = wr_en && (wr_strobe != 4'b0000) && (addr == A_CTRL);
      tick_s       = en_s && (cnt_r == div_s) && !ctrl_wr_s;
      mtime_next_s = mtime_r + {63'd0, tick_s};
      pend_s       = '0;
      for (int k = 0; k < NUM_CMP; k++) begin
         pend_s[k] = (mtime_r >= cmp_r[k]);
      end
   end

   assign irq          = ie_s & pend_s;
   assign irq_any      = |irq;
   assign time_rd_data = mtime_r;

   // Register state: divider, mtime, control, compare channels and read shadow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime_r  <= 64'd0;
         ctrl_r   <= CTRL_RST;
         cnt_r    <= 16'd0;
         shadow_r <= 32'd0;
         for (int k = 0; k < NUM_CMP; k++) begin
            cmp_r[k] <= 64'hFFFF_FFFF_FFFF_FFFF;
         end
      end else begin
         if (ctrl_wr_s || tick_s) begin
            cnt_r <= 16'd0;
         end else if (en_s) begin
            cnt_r <= cnt_r + 16'd1;
         end else begin
            cnt_r <= cnt_r;
         end

         // A written half overrides the increment; the other half still advances
         mtime_r <= mtime_next_s;
         if (wr_en && (addr == A_MTIME_LO)) begin
            mtime_r[31:0] <= byte_merge(mtime_next_s[31:0], wr_data, wr_strobe);
         end
         if (wr_en && (addr == A_MTIME_HI)) begin
            mtime_r[63:32] <= byte_merge(mtime_next_s[63:32], wr_data, wr_strobe);
         end

         if (ctrl_wr_s) begin
            ctrl_r <= byte_merge(ctrl_r, wr_data, wr_strobe) & CTRL_MASK;
         end

         for (int k = 0; k < NUM_CMP; k++) begin
            if (wr_en && (addr == ADDR_W'(4 + 2 * k))) begin
               cmp_r[k][31:0] <= byte_merge(cmp_r[k][31:0], wr_data, wr_strobe);
            end
            if (wr_en && (addr == ADDR_W'(5 + 2 * k))) begin
               cmp_r[k][63:32] <= byte_merge(cmp_r[k][63:32], wr_data, wr_strobe);
            end
         end

         if (rd_en && (addr == A_MTIME_LO)) begin
            shadow_r <= mtime_r[63:32];
         end
      end
   end

   // DBus read mux; MTIME_HI returns the shadow captured by the last LO read
   always_comb begin
      rd_data = 32'd0;
      if (rd_en) begin
         case (addr)
            A_MTIME_LO: rd_data = mtime_r[31:0];
            A_MTIME_HI: rd_data = shadow_r;
            A_CTRL:     rd_data = ctrl_r;
            A_PEND:     rd_data = 32'(pend_s);
            default: begin
               for (int k = 0; k < NUM_CMP; k++) begin
                  rd_data = (addr == ADDR_W'(4 + 2 * k)) ? cmp_r[k][31:0]  : rd_data;
                  rd_data = (addr == ADDR_W'(5 + 2 * k)) ? cmp_r[k][63:32] : rd_data;
               end
            end
         endcase
      end else begin
         rd_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_mtime_multi.sv
// Directed self-checking bench for mtime_multi (CLK_PERIOD=10, NUM_CMP=4).
module tb_mtime_multi;

   logic        clk;
   logic        rst_n;
   logic        rd_en;
   logic        wr_en;
   logic [3:0]  addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strobe;
   logic [31:0] rd_data;
   logic [63:0] time_rd_data;
   logic [3:0]  irq;
   logic        irq_any;

   int n_cmp = 0;
   int n_err = 0;

   mtime_multi #(.CLK_PERIOD(10), .NUM_CMP(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .addr         (addr),
      .wr_data      (wr_data),
      .wr_strobe    (wr_strobe),
      .rd_data      (rd_data),
      .time_rd_data (time_rd_data),
      .irq          (irq),
      .irq_any      (irq_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one write from a negedge; it lands on the following posedge
   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_en     = 1'b1;
      addr      = a;
      wr_data   = d;
      wr_strobe = s;
      @(negedge clk);
      wr_en     = 1'b0;
      wr_strobe = 4'b0000;
   endtask

   task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      rd_en = 1'b1;
      addr  = a;
      #1;
      check_val(tag, {32'd0, rd_data}, {32'd0, exp});
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      addr      = 4'd0;
      wr_data   = 32'd0;
      wr_strobe = 4'b0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      addr  = 4'd2;
      #1;
      check_val("rst_time", time_rd_data, 64'd0);
      check_val("rst_irq", {63'd0, irq_any}, 64'd0);
      check_val("rd_idle_zero", {32'd0, rd_data}, 64'd0);

      // Reset divider 99: first tick on the 100th edge
      repeat (99) @(negedge clk);
      check_val("tick99_time", time_rd_data, 64'd0);
      @(negedge clk);
      check_val("tick100_time", time_rd_data, 64'd1);
      check_val("tick100_irq", {60'd0, irq}, 64'd0);

      // DIV=3, IE_0, CMP0=5
      bus_wr(4'd2, 32'h0003_0100, 4'hF);
      bus_wr(4'd0, 32'd0, 4'hF);
      bus_wr(4'd1, 32'd0, 4'hF);
      bus_wr(4'd4, 32'd5, 4'hF);
      bus_wr(4'd5, 32'd0, 4'hF);
      bus_wr(4'd2, 32'h0003_0101, 4'hF);
      repeat (3) @(negedge clk);
      check_val("div3_t3", time_rd_data, 64'd0);
      @(negedge clk);
      check_val("div3_t4", time_rd_data, 64'd1);
      repeat (15) @(negedge clk);
      check_val("div3_t19", time_rd_data, 64'd4);
      check_val("div3_t19_irq", {60'd0, irq}, 64'd0);
      @(negedge clk);
      check_val("div3_t20", time_rd_data, 64'd5);
      check_val("cmp0_irq", {60'd0, irq}, 64'd1);
      check_val("cmp0_irq_any", {63'd0, irq_any}, 64'd1);
      bus_wr(4'd5, 32'd1, 4'hF);
      check_val("cmp0_raised_irq", {60'd0, irq}, 64'd0);

      // Carry across halves with DIV=0
      bus_wr(4'd2, 32'h0000_0000, 4'hF);
      bus_wr(4'd0, 32'hFFFF_FFFF, 4'hF);
      bus_wr(4'd1, 32'd0, 4'hF);
      bus_wr(4'd2, 32'h0000_0001, 4'hF);
      check_val("wrap_pre", time_rd_data, 64'h0000_0000_FFFF_FFFF);
      @(negedge clk);
      check_val("wrap_carry", time_rd_data, 64'h0000_0001_0000_0000);
      bus_rd(4'd0, 32'd0, "coh_lo");
      bus_rd(4'd1, 32'd1, "coh_hi");

      // Shadow holds across a hi write until the next LO read
      bus_wr(4'd2, 32'h0000_0000, 4'hF);
      bus_wr(4'd1, 32'd7, 4'hF);
      bus_rd(4'd1, 32'd1, "shadow_hold");
      check_val("live_time", time_rd_data, 64'h0000_0007_0000_0002);
      bus_rd(4'd0, 32'd2, "shadow_lo");
      bus_rd(4'd1, 32'd7, "shadow_new");

      // Byte-merge write coinciding with a tick
      bus_wr(4'd0, 32'h1122_3344, 4'hF);
      bus_wr(4'd1, 32'd0, 4'hF);
      bus_wr(4'd2, 32'h0000_0001, 4'hF);
      bus_wr(4'd0, 32'h0000_AB00, 4'b0010);
      check_val("byte_merge", time_rd_data, 64'h0000_0000_1122_AB45);
      bus_wr(4'd2, 32'h0000_0000, 4'hF);
      bus_wr(4'd0, 32'hFFFF_FFFF, 4'b0000);
      check_val("strobe0_noop", time_rd_data, 64'h0000_0000_1122_AB45);

      // PEND independent of IE, then enable IE_2
      bus_wr(4'd8, 32'd0, 4'hF);
      bus_wr(4'd9, 32'd0, 4'hF);
      bus_rd(4'd3, 32'h0000_0004, "pend");
      check_val("pend_no_irq", {60'd0, irq}, 64'd0);
      bus_wr(4'd2, 32'h0000_0400, 4'hF);
      check_val("ie2_irq", {60'd0, irq}, 64'h4);
      check_val("ie2_irq_any", {63'd0, irq_any}, 64'd1);
      repeat (50) @(negedge clk);
      check_val("en0_frozen", time_rd_data, 64'h0000_0000_1122_AB45);
      bus_wr(4'd2, 32'h0000_0000, 4'hF);
      check_val("ie2_clear", {60'd0, irq}, 64'd0);
      bus_rd(4'd12, 32'd0, "unmapped");

      // Simultaneous read and write of the same word
      rd_en     = 1'b1;
      wr_en     = 1'b1;
      addr      = 4'd4;
      wr_data   = 32'd9;
      wr_strobe = 4'hF;
      #1;
      check_val("rw_pre", {32'd0, rd_data}, 64'd5);
      @(negedge clk);
      wr_en     = 1'b0;
      wr_strobe = 4'b0000;
      #1;
      check_val("rw_post", {32'd0, rd_data}, 64'd9);
      @(negedge clk);
      rd_en = 1'b0;

      // Reset mid-operation
      bus_wr(4'd2, 32'h0000_0001, 4'hF);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("mid_rst_time", time_rd_data, 64'd0);
      check_val("mid_rst_irq", {60'd0, irq}, 64'd0);
      bus_rd(4'd2, 32'h0063_0001, "mid_rst_ctrl");
      bus_rd(4'd4, 32'hFFFF_FFFF, "mid_rst_cmp0");
      bus_rd(4'd1, 32'd0, "mid_rst_shadow");
      bus_rd(4'd3, 32'd0, "mid_rst_pend");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
